// File: rtl/ddr_vec_op_pkg.sv
// Shared types and helpers for the DDR vector-operation engine.
//   state_t  : engine phase encoding
//   op_t     : element-wise operation selected by op_sel
//   RD_CMD / WR_CMD : UI command codes
//   apply_op : element-wise operation, evaluated at OP_MAX_W bits; callers
//              keep the low APP_DATA_WIDTH bits, which gives the wrap-around
//              result because add/sub/xor low bits never depend on high bits.
package ddr_vec_op_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_FILL = 3'd1,
      ST_RD_A = 3'd2,
      ST_RD_B = 3'd3,
      ST_WB   = 3'd4,
      ST_CHK  = 3'd5,
      ST_DONE = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD    = 2'd0,
      OP_SUB    = 2'd1,
      OP_XOR    = 2'd2,
      OP_PASS_A = 2'd3
   } op_t;

   localparam logic [2:0] RD_CMD = 3'b001;
   localparam logic [2:0] WR_CMD = 3'b000;

   // Widest APP_DATA_WIDTH the engine supports.
   localparam int OP_MAX_W = 512;

   function automatic logic [OP_MAX_W-1:0] apply_op(
      input op_t                 op,
      input logic [OP_MAX_W-1:0] a,
      input logic [OP_MAX_W-1:0] b
   );
      logic [OP_MAX_W-1:0] r;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_XOR:  r = a ^ b;
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ddr_ui_burst_issuer.sv
// Issues a burst of UI commands: count commands starting at base, address
// advancing by STRIDE per accepted command. Shared by every engine phase.
// Ports:
//   clk, clr          : clock, synchronous clear (engine reset/abort)
//   launch            : load cmd/base/count and begin issuing
//   launch_cmd/base/count : burst description sampled on launch
//   app_rdy           : UI command ready
//   app_en/app_cmd/app_addr : UI command outputs, held until accepted
//   accepted          : commands accepted since the last launch
module ddr_ui_burst_issuer
   import ddr_vec_op_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                CNT_W      = 8,
   parameter int                STRIDE     = 8,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              launch,
   input  logic [2:0]        launch_cmd,
   input  logic [ADDR_W-1:0] launch_base,
   input  logic [CNT_W-1:0]  launch_count,
   input  logic              app_rdy,
   output logic              app_en,
   output logic [2:0]        app_cmd,
   output logic [ADDR_W-1:0] app_addr,
   output logic [CNT_W-1:0]  accepted
);

   // Down-counter of commands still to be accepted; terminal count at 1
   // drops app_en on the cycle the last command is taken.
   logic [CNT_W-1:0] remaining;

   always_ff @(posedge clk) begin
      if (clr) begin
         app_en    <= 1'b0;
         app_cmd   <= WR_CMD;
         app_addr  <= RESET_ADDR;
         accepted  <= '0;
         remaining <= '0;
      end else if (launch) begin
         app_en    <= (launch_count != '0);
         app_cmd   <= launch_cmd;
         app_addr  <= launch_base;
         accepted  <= '0;
         remaining <= launch_count;
      end else if (app_en && app_rdy) begin
         accepted  <= accepted + CNT_W'(1);
         remaining <= remaining - CNT_W'(1);
         app_addr  <= app_addr + ADDR_W'(STRIDE);
         if (remaining == CNT_W'(1))
            app_en <= 1'b0;
      end
   end

endmodule

// File: rtl/ddr_vec_op_engine.sv
// DDR vector-operation engine. Fills operand regions A and B with a seeded
// ramp, reads A into a local buffer, folds B into it with op_sel, writes the
// result region and (optionally) reads it back and compares.
// Optional feature macro: DDR_VEC_OP_CHECK_EN -- when defined, WB is followed
// by a CHK readback phase; otherwise WB goes straight to DONE and
// compare_error / err_cnt are tied to 0.
// Ports:
//   clk, rst (sync, active-high), init_calib_complete
//   UI command : app_cmd, app_addr, app_en, app_rdy
//   UI write   : app_wdf_data, app_wdf_mask (0), app_wdf_end, app_wdf_wren, app_wdf_rdy
//   UI read    : app_rd_data, app_rd_data_valid
//   control    : start, op_sel, seed -> busy, done, compare_error, err_cnt
//
// state   | meaning
// IDLE    | waiting for start
// FILL    | write 2*VEC_LEN ramp words from BASE_A (A then B)
// RD_A    | read A into vec_buf
// RD_B    | read B, vec_buf[i] = op(vec_buf[i], B[i])
// WB      | write vec_buf to BASE_R
// CHK     | read BASE_R back and compare against vec_buf
// DONE    | finished, done held until next start
module ddr_vec_op_engine
   import ddr_vec_op_pkg::*;
#(
   parameter int APP_DATA_WIDTH = 32,
   parameter int APP_ADDR_WIDTH = 32,
   parameter int VEC_LEN        = 10,
   parameter int ADDR_STRIDE    = 8,
   parameter int BASE_A         = 0,
   parameter int BASE_B         = 8 * VEC_LEN,
   parameter int BASE_R         = 400
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        init_calib_complete,
   input  logic                        app_rdy,
   input  logic                        app_wdf_rdy,
   input  logic                        app_rd_data_valid,
   input  logic [APP_DATA_WIDTH-1:0]   app_rd_data,
   output logic [2:0]                  app_cmd,
   output logic [APP_ADDR_WIDTH-1:0]   app_addr,
   output logic                        app_en,
   output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
   output logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
   output logic                        app_wdf_end,
   output logic                        app_wdf_wren,
   input  logic                        start,
   input  logic [1:0]                  op_sel,
   input  logic [APP_DATA_WIDTH-1:0]   seed,
   output logic                        busy,
   output logic                        done,
   output logic                        compare_error,
   output logic [6:0]                  err_cnt
);

   localparam int                CNT_W     = 8;
   localparam logic [CNT_W-1:0]  VEC_CNT   = CNT_W'(VEC_LEN);
   localparam logic [CNT_W-1:0]  VEC_LAST  = CNT_W'(VEC_LEN - 1);
   localparam logic [CNT_W-1:0]  FILL_CNT  = CNT_W'(2 * VEC_LEN);
   localparam int                IDX_W     = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int                BUF_N     = 1 << IDX_W;

   state_t                      state, state_nxt;
   logic                        calib_q, abort, start_ok;
   op_t                         op_q;
   logic [APP_DATA_WIDTH-1:0]   seed_q;
   // Data-beat counter: write beats in FILL/WB, returned read beats otherwise.
   logic [CNT_W-1:0]            dcnt;
   logic [CNT_W-1:0]            cmd_cnt, phase_total;
   logic [IDX_W-1:0]            idx;
   logic                        rd_phase, rd_beat, wr_beat, last_rd_beat, wr_phase_done;
   logic [APP_DATA_WIDTH-1:0]   vec_buf [BUF_N];
   logic [OP_MAX_W-1:0]         op_full;
   logic [APP_DATA_WIDTH-1:0]   op_res;

   logic                        launch;
   logic [2:0]                  launch_cmd;
   logic [APP_ADDR_WIDTH-1:0]   launch_base;
   logic [CNT_W-1:0]            launch_count;

   assign abort        = rst || !calib_q;
   assign start_ok     = start && calib_q && (state == ST_IDLE || state == ST_DONE);
   assign phase_total  = (state == ST_FILL) ? FILL_CNT : VEC_CNT;
   assign idx          = dcnt[IDX_W-1:0];
   assign rd_phase     = (state == ST_RD_A) || (state == ST_RD_B) || (state == ST_CHK);
   assign rd_beat      = rd_phase && app_rd_data_valid;
   assign last_rd_beat = rd_beat && (dcnt == VEC_LAST);
   assign app_wdf_wren = ((state == ST_FILL) || (state == ST_WB)) && (dcnt != phase_total);
   assign app_wdf_end  = app_wdf_wren;
   assign app_wdf_mask = '0;
   assign wr_beat      = app_wdf_wren && app_wdf_rdy;
   assign wr_phase_done = (cmd_cnt == phase_total) && (dcnt == phase_total);
   assign busy         = (state == ST_FILL) || (state == ST_RD_A) || (state == ST_RD_B) ||
                         (state == ST_WB)   || (state == ST_CHK);

   assign op_full = apply_op(op_q, OP_MAX_W'(vec_buf[idx]), OP_MAX_W'(app_rd_data));
   assign op_res  = op_full[APP_DATA_WIDTH-1:0];

   always_comb begin
      app_wdf_data = seed_q + (APP_DATA_WIDTH'(dcnt) << 3);
      if (state == ST_WB)
         app_wdf_data = vec_buf[idx];
   end

   always_comb begin
      state_nxt    = state;
      launch       = 1'b0;
      launch_cmd   = WR_CMD;
      launch_base  = APP_ADDR_WIDTH'(BASE_A);
      launch_count = VEC_CNT;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start_ok) begin
               state_nxt    = ST_FILL;
               launch       = 1'b1;
               launch_count = FILL_CNT;
            end
         end
         ST_FILL: begin
            if (wr_phase_done) begin
               state_nxt  = ST_RD_A;
               launch     = 1'b1;
               launch_cmd = RD_CMD;
            end
         end
         ST_RD_A: begin
            if (last_rd_beat) begin
               state_nxt   = ST_RD_B;
               launch      = 1'b1;
               launch_cmd  = RD_CMD;
               launch_base = APP_ADDR_WIDTH'(BASE_B);
            end
         end
         ST_RD_B: begin
            if (last_rd_beat) begin
               state_nxt   = ST_WB;
               launch      = 1'b1;
               launch_base = APP_ADDR_WIDTH'(BASE_R);
            end
         end
         ST_WB: begin
            if (wr_phase_done) begin
`ifdef DDR_VEC_OP_CHECK_EN
               state_nxt   = ST_CHK;
               launch      = 1'b1;
               launch_cmd  = RD_CMD;
               launch_base = APP_ADDR_WIDTH'(BASE_R);
`else
               state_nxt   = ST_DONE;
`endif
            end
         end
         ST_CHK: begin
            if (last_rd_beat)
               state_nxt = ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         calib_q <= 1'b0;
      else
         calib_q <= init_calib_complete;
   end

   always_ff @(posedge clk) begin
      if (abort) begin
         state  <= ST_IDLE;
         dcnt   <= '0;
         done   <= 1'b0;
         op_q   <= OP_ADD;
         seed_q <= '0;
      end else begin
         state <= state_nxt;
         if (launch)
            dcnt <= '0;
         else if (wr_beat || rd_beat)
            dcnt <= dcnt + CNT_W'(1);
         if (start_ok) begin
            op_q   <= op_t'(op_sel);
            seed_q <= seed;
            done   <= 1'b0;
         end else if (state_nxt == ST_DONE) begin
            done <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!abort && rd_beat) begin
         if (state == ST_RD_A)
            vec_buf[idx] <= app_rd_data;
         else if (state == ST_RD_B)
            vec_buf[idx] <= op_res;
      end
   end

`ifdef DDR_VEC_OP_CHECK_EN
   always_ff @(posedge clk) begin
      if (abort || start_ok) begin
         compare_error <= 1'b0;
         err_cnt       <= '0;
      end else if (state == ST_CHK && rd_beat && app_rd_data != vec_buf[idx]) begin
         compare_error <= 1'b1;
         if (err_cnt != 7'd127)
            err_cnt <= err_cnt + 7'd1;
      end
   end
`else
   assign compare_error = 1'b0;
   assign err_cnt       = '0;
`endif

   ddr_ui_burst_issuer #(
      .ADDR_W     (APP_ADDR_WIDTH),
      .CNT_W      (CNT_W),
      .STRIDE     (ADDR_STRIDE),
      .RESET_ADDR (APP_ADDR_WIDTH'(BASE_A))
   ) u_issuer (
      .clk          (clk),
      .clr          (abort),
      .launch       (launch),
      .launch_cmd   (launch_cmd),
      .launch_base  (launch_base),
      .launch_count (launch_count),
      .app_rdy      (app_rdy),
      .app_en       (app_en),
      .app_cmd      (app_cmd),
      .app_addr     (app_addr),
      .accepted     (cmd_cnt)
   );

endmodule

// File: doc/ddr_vec_op_engine.md
DDR_VEC_OP_ENGINE -- requirements
Module: ddr_vec_op_engine

Interface
REQ-001 SHALL have parameter APP_DATA_WIDTH, default 32, meaning UI data width; legal values are multiples of 8.
REQ-002 SHALL have parameter APP_ADDR_WIDTH, default 32, meaning UI address width.
REQ-003 SHALL have parameter VEC_LEN, default 10, meaning words per operand vector; legal range is 1..64.
REQ-004 SHALL have parameter ADDR_STRIDE, default 8, meaning address increment per word.
REQ-005 SHALL have parameters BASE_A (default 0), BASE_B (default 8*VEC_LEN) and BASE_R (default 400), meaning the start addresses of operand A, operand B and the result region.
REQ-006 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); rst is synchronous and active-high.
REQ-007 SHALL have init_calib_complete (in, 1), app_rdy (in, 1), app_wdf_rdy (in, 1), app_rd_data_valid (in, 1) and app_rd_data (in, APP_DATA_WIDTH).
REQ-008 SHALL have app_cmd (out, 3), app_addr (out, APP_ADDR_WIDTH), app_en (out, 1), app_wdf_data (out, APP_DATA_WIDTH), app_wdf_mask (out, APP_DATA_WIDTH/8, tied 0), app_wdf_end (out, 1) and app_wdf_wren (out, 1).
REQ-009 SHALL have start (in, 1), op_sel (in, 2: 0=ADD, 1=SUB, 2=XOR, 3=PASS_A) and seed (in, APP_DATA_WIDTH); op_sel and seed are sampled on an accepted start.
REQ-010 SHALL have busy (out, 1), done (out, 1), compare_error (out, 1) and err_cnt (out, 7).

Function
REQ-011 SHALL implement the states IDLE, FILL, RD_A, RD_B, WB, CHK and DONE.
REQ-012 SHALL accept start only in IDLE or DONE with init_calib_complete registered high; start in any other state is ignored.
REQ-013 SHALL, in FILL, write 2*VEC_LEN words at BASE_A+k*ADDR_STRIDE with data seed+8*k (mod 2^W), k=0..2*VEC_LEN-1; A occupies k<VEC_LEN and B occupies k>=VEC_LEN, with BASE_B assumed contiguous.
REQ-014 SHALL count a command as accepted only on a cycle with app_en&app_rdy; app_en, app_cmd and app_addr SHALL stay stable until acceptance.
REQ-015 SHALL count write data as accepted only on a cycle with app_wdf_wren&app_wdf_rdy; app_wdf_end SHALL equal app_wdf_wren; data and command counters run independently.
REQ-016 SHALL leave FILL or WB only when both the command count and the data count equal the phase total.
REQ-017 SHALL, in RD_A, issue VEC_LEN reads from BASE_A and store the returned words in order into buf[0..VEC_LEN-1].
REQ-018 SHALL, in RD_B, issue VEC_LEN reads from BASE_B and overwrite buf[i] with op(buf[i], B[i]) as each word returns.
REQ-019 SHALL leave a read phase only when VEC_LEN read-data beats have returned; read commands may run ahead of returned data.
REQ-020 SHALL, in WB, write buf[0..VEC_LEN-1] to BASE_R+i*ADDR_STRIDE.
REQ-021 SHALL, in CHK, read back the result region and compare each returned word with buf[i]; on each mismatch it SHALL set compare_error sticky and increment err_cnt, saturating at 127.
REQ-022 SHALL compute all arithmetic modulo 2^APP_DATA_WIDTH; SUB is A-B.
REQ-023 SHALL hold busy high from FILL through CHK; done SHALL be held high in DONE until the next accepted start, which clears compare_error and err_cnt.
REQ-024 SHALL keep app_en and app_wdf_wren low in IDLE and DONE, and ignore app_rd_data_valid outside RD_A, RD_B and CHK.
REQ-025 SHALL, when VEC_LEN=1, complete every phase with a single command.

Reset
REQ-026 SHALL, on rst or registered init_calib_complete low, go to IDLE and clear all counters, app_en, app_wdf_wren, busy, done, compare_error and err_cnt to 0, with app_cmd=WR(000) and app_addr=BASE_A.
REQ-027 SHALL, on reset mid-operation, abort with no further UI traffic; read data still in flight is discarded.

Configuration
REQ-028 SHALL, with DDR_VEC_OP_CHECK_EN defined, include the CHK phase, with WB proceeding to CHK and then to DONE.
REQ-029 SHALL, without DDR_VEC_OP_CHECK_EN, go from WB directly to DONE, with compare_error and err_cnt tied to 0.

Structure
REQ-030 SHALL place the state enum, the op_sel enum, RD_CMD=3'b001, WR_CMD=3'b000 and the op function in the package ddr_vec_op_pkg.
REQ-031 SHALL use one sub-module, ddr_ui_burst_issuer, which issues N commands from a base address with a stride and reports the accepted count; it is instantiated once and reused by every phase.

Verification
REQ-032 SHALL verify: VEC_LEN=10, seed=0, ADD, app_rdy=1 -> R[i]=16i+80 and done with err_cnt=0.
REQ-033 SHALL verify: SUB with seed=5 -> R[i]=2^32-80 for all i.
REQ-034 SHALL verify: app_rdy and app_wdf_rdy toggled randomly at 50% -> exactly 20+10+10+10+10 commands accepted and results unchanged.
REQ-035 SHALL verify: the memory model corrupts R[3] on readback -> compare_error=1 and err_cnt=1 with CHK_EN defined, and 0 without it.
REQ-036 SHALL verify: rst asserted during RD_B -> next cycle IDLE with app_en=0, and a fresh start succeeds.
REQ-037 SHALL verify: start pulsed while busy -> ignored, with the command count unchanged.
